mem_bus_arbiter: RTL

- Shares the single cache-line memory port between the instruction cache (port 0) and the data cache (port 1).
- Both requesters and the memory side use the same handshake: level request, one-cycle reqack, one-cycle done with a full line.
- The block grants one requester at a time, latches its command, forwards it downstream and routes the response back.
- It also runs a watchdog on outstanding transactions.

---
 rtl/mem_bus_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single cache-line memory port between ICache (port 0) and DCache (port 1).
// Define MEM_BUS_ARBITER_RR_EN for round-robin conflict resolution; otherwise DCache has fixed priority.
module mem_bus_arbiter #(
  parameter int AddrWidth     = 64,
  parameter int LineWidth     = 512,
  parameter int TimeoutCycles = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req0,
  output logic                 reqack0,
  input  logic                 wren0,
  input  logic [AddrWidth-1:0] addr0,
  input  logic [LineWidth-1:0] wdata0,
  output logic [LineWidth-1:0] rdata0,
  output logic                 done0,
  input  logic                 req1,
  output logic                 reqack1,
  input  logic                 wren1,
  input  logic [AddrWidth-1:0] addr1,
  input  logic [LineWidth-1:0] wdata1,
  output logic [LineWidth-1:0] rdata1,
  output logic                 done1,
  output logic                 mreq,
  input  logic                 mreqack,
  output logic                 mwren,
  output logic [AddrWidth-1:0] maddr,
  output logic [LineWidth-1:0] mwdata,
  input  logic [LineWidth-1:0] mrdata,
  input  logic                 mdone,
  output logic                 busy,
  output logic                 timeout_err
);

`ifdef MEM_BUS_ARBITER_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  localparam int WdWidth = $clog2(TimeoutCycles + 1);
  localparam logic [WdWidth-1:0] WdLimit = WdWidth'(TimeoutCycles);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

  state_e               state_q;
  logic                 grant_q;
  logic                 last_grant_q;
  logic                 cmd_wr_q;
  logic [WdWidth-1:0]   wd_q;
  logic                 timeout_err_q;
  logic                 reqack0_q, reqack1_q;
  logic                 done0_q, done1_q;
  logic [LineWidth-1:0] rdata0_q, rdata1_q;
  logic                 mreq_q, mwren_q;
  logic [AddrWidth-1:0] maddr_q;
  logic [LineWidth-1:0] mwdata_q;
  logic                 win_d;

  // A lone requester always wins; only a conflict consults the policy.
  always_comb begin
    win_d = req1;
    if (req0 && req1) begin
      win_d = RrEn ? ~last_grant_q : 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      cmd_wr_q      <= 1'b0;
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
      reqack0_q     <= 1'b0;
      reqack1_q     <= 1'b0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      mreq_q        <= 1'b0;
      mwren_q       <= 1'b0;
      maddr_q       <= '0;
      mwdata_q      <= '0;
    end else begin
      reqack0_q <= 1'b0;
      reqack1_q <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            mwren_q      <= win_d ? wren1 : wren0;
            cmd_wr_q     <= win_d ? wren1 : wren0;
            maddr_q      <= win_d ? addr1 : addr0;
            mwdata_q     <= win_d ? wdata1 : wdata0;
            reqack0_q    <= ~win_d;
            reqack1_q    <= win_d;
            mreq_q       <= 1'b1;
            grant_q      <= win_d;
            last_grant_q <= win_d;
            wd_q         <= '0;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (wd_q != WdLimit) begin
            wd_q <= wd_q + 1'b1;
            if (wd_q == WdLimit - 1'b1) begin
              timeout_err_q <= 1'b1;
            end
          end
          if (state_q == S_ISSUE && mreqack) begin
            mreq_q  <= 1'b0;
            mwren_q <= 1'b0;
            state_q <= S_WAIT;
          end
          // Completion takes precedence over the ISSUE->WAIT move when both arrive together.
          if (mdone) begin
            mreq_q  <= 1'b0;
            mwren_q <= 1'b0;
            if (grant_q) begin
              done1_q  <= 1'b1;
              rdata1_q <= cmd_wr_q ? '0 : mrdata;
            end else begin
              done0_q  <= 1'b1;
              rdata0_q <= cmd_wr_q ? '0 : mrdata;
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign reqack0     = reqack0_q;
  assign reqack1     = reqack1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign mreq        = mreq_q;
  assign mwren       = mwren_q;
  assign maddr       = maddr_q;
  assign mwdata      = mwdata_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = timeout_err_q;

endmodule
